// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// seg7_pkg - active-low 7-segment patterns and single-digit BCD step helpers
// Rev 1.0
// ============================================================================
package seg7_pkg;

    // bit0 = a ... bit6 = g, active low
    localparam logic [6:0] SEG_PATTERN [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Returns {carry, digit}
    function automatic logic [4:0] bcd_inc(input logic [3:0] i_digit);
        logic [4:0] r;
        if (i_digit >= 4'd9) r = {1'b1, 4'd0};
        else                 r = {1'b0, i_digit + 4'd1};
        return r;
    endfunction

    // Returns {borrow, digit}
    function automatic logic [4:0] bcd_dec(input logic [3:0] i_digit);
        logic [4:0] r;
        if (i_digit == 4'd0) r = {1'b1, 4'd9};
        else                 r = {1'b0, i_digit - 4'd1};
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// seg7_decode - combinational nibble to active-low 7-segment pattern
// Rev 1.0
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_PATTERN[i_digit];

endmodule
`default_nettype wire

// File: rtl/rev_counter_disp.sv
`default_nettype none
// ============================================================================
// rev_counter_disp - prescaled up/down hex/BCD counter with multiplexed display
// Rev 1.0
// ============================================================================
module rev_counter_disp #(
    parameter int DIGITS   = 4,
    parameter int CLK_DIV  = 5_000_000,
    parameter int SCAN_DIV = 50_000,
    parameter int BCD      = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  rc,
    output logic                  tick,
    output logic [6:0]            segment,
    output logic [DIGITS-1:0]     an
);
    import seg7_pkg::*;

    localparam int c_W      = 4 * DIGITS;
    localparam int c_PRE_W  = $clog2(CLK_DIV);
    localparam int c_SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_PRE_W-1:0]  c_PRE_MAX  = c_PRE_W'(CLK_DIV - 1);
    localparam logic [c_SCAN_W-1:0] c_SCAN_MAX = c_SCAN_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_MAX  = c_IDX_W'(DIGITS - 1);
    localparam logic [c_W-1:0]      c_ONE      = c_W'(1);

    logic [c_PRE_W-1:0]  r_pre;
    logic [c_W-1:0]      r_cnt;
    logic                r_tick;
    logic [c_SCAN_W-1:0] r_scan;
    logic [c_IDX_W-1:0]  r_idx;
    logic [DIGITS-1:0]   r_an;
    logic [6:0]          r_seg;

    logic                w_tick;
    logic [c_W-1:0]      w_cnt_step;
    logic [c_W-1:0]      w_load_val;
    logic [c_W-1:0]      w_max;
    logic [3:0]          w_nibble;
    logic [6:0]          w_seg;
    logic [DIGITS-1:0]   w_an;

    assign w_tick = en && (r_pre == c_PRE_MAX);

    generate
        if (BCD != 0) begin : g_bcd
            // w_carry[i] is the carry (up) or borrow (down) into digit i
            logic [DIGITS:0] w_carry;
            assign w_carry[0] = 1'b1;
            for (genvar i = 0; i < DIGITS; i++) begin : g_digit
                logic [4:0] w_inc;
                logic [4:0] w_dec;
                assign w_inc = bcd_inc(r_cnt[4*i +: 4]);
                assign w_dec = bcd_dec(r_cnt[4*i +: 4]);
                assign w_cnt_step[4*i +: 4] = !w_carry[i] ? r_cnt[4*i +: 4]
                                            : (up ? w_inc[3:0] : w_dec[3:0]);
                assign w_carry[i+1] = w_carry[i] & (up ? w_inc[4] : w_dec[4]);
                assign w_load_val[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9
                                            : load_val[4*i +: 4];
                assign w_max[4*i +: 4] = 4'd9;
            end
        end else begin : g_hex
            assign w_cnt_step = up ? (r_cnt + c_ONE) : (r_cnt - c_ONE);
            assign w_load_val = load_val;
            assign w_max      = '1;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre  <= '0;
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (load) begin
                r_cnt <= w_load_val;
                r_pre <= '0;
            end else if (w_tick) begin
                r_cnt  <= w_cnt_step;
                r_pre  <= '0;
                r_tick <= 1'b1;
            end else if (en) begin
                r_pre <= r_pre + c_PRE_W'(1);
            end
        end
    end

    // Scan runs independently of en so the display stays lit while paused
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= '0;
            r_idx  <= '0;
        end else if (r_scan == c_SCAN_MAX) begin
            r_scan <= '0;
            r_idx  <= (r_idx == c_IDX_MAX) ? '0 : r_idx + c_IDX_W'(1);
        end else begin
            r_scan <= r_scan + c_SCAN_W'(1);
        end
    end

    always_comb begin
        w_nibble = r_cnt[3:0];
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) w_nibble = r_cnt[4*i +: 4];
        end
    end

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_an
            assign w_an[i] = (r_idx != c_IDX_W'(i));
        end
    endgenerate

    seg7_decode u_decode (
        .i_digit (w_nibble),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_an;
            r_seg <= w_seg;
        end
    end

    assign cnt     = r_cnt;
    assign tick    = r_tick;
    assign an      = r_an;
    assign segment = r_seg;
    assign rc      = up ? (r_cnt == w_max) : (r_cnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_rev_counter_disp.sv
`default_nettype none
// ============================================================================
// tb_rev_counter_disp - hex and BCD instances driven in lockstep against a model
// Rev 1.0
// ============================================================================
module tb_rev_counter_disp;

    localparam int DIGITS   = 2;
    localparam int CLK_DIV  = 4;
    localparam int SCAN_DIV = 2;

    localparam logic [6:0] SEG_REF [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;

    logic [7:0] cnt_h, cnt_b;
    logic       rc_h, rc_b, tick_h, tick_b;
    logic [6:0] seg_h, seg_b;
    logic [1:0] an_h, an_b;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    int         m_pre, m_bcd, m_idx, m_scan;
    logic [7:0] m_hex;
    logic       m_tick;
    logic [1:0] m_an;
    logic [6:0] m_seg_h, m_seg_b;

    always #5 clk = ~clk;

    rev_counter_disp #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .SCAN_DIV(SCAN_DIV), .BCD(0)) u_hex (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
        .cnt(cnt_h), .rc(rc_h), .tick(tick_h), .segment(seg_h), .an(an_h)
    );

    rev_counter_disp #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .SCAN_DIV(SCAN_DIV), .BCD(1)) u_bcd (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
        .cnt(cnt_b), .rc(rc_b), .tick(tick_b), .segment(seg_b), .an(an_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [7:0] dec2bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int clamp_dec(input logic [7:0] v);
        int hi, lo;
        hi = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        lo = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return hi * 10 + lo;
    endfunction

    task automatic model_reset();
        m_pre = 0; m_bcd = 0; m_idx = 0; m_scan = 0;
        m_hex = 8'h00; m_tick = 1'b0;
        m_an = 2'b11; m_seg_h = 7'h7F; m_seg_b = 7'h7F;
    endtask

    task automatic model_step(input logic ld, input logic [7:0] lv, input logic e, input logic u);
        logic [7:0] b;
        b = dec2bcd(m_bcd);
        m_an    = (m_idx == 0) ? 2'b10 : 2'b01;
        m_seg_h = SEG_REF[(m_idx == 0) ? m_hex[3:0] : m_hex[7:4]];
        m_seg_b = SEG_REF[(m_idx == 0) ? b[3:0] : b[7:4]];
        if (ld) begin
            m_hex = lv; m_bcd = clamp_dec(lv); m_pre = 0; m_tick = 1'b0;
        end else if (e && m_pre == CLK_DIV - 1) begin
            m_hex = u ? m_hex + 8'd1 : m_hex - 8'd1;
            m_bcd = u ? (m_bcd + 1) % 100 : (m_bcd + 99) % 100;
            m_pre = 0; m_tick = 1'b1;
        end else begin
            if (e) m_pre++;
            m_tick = 1'b0;
        end
        m_scan++;
        if (m_scan == SCAN_DIV) begin
            m_scan = 0;
            m_idx  = (m_idx + 1) % DIGITS;
        end
    endtask

    task automatic check_all(input logic u);
        chk("cnt_hex",  cnt_h,  m_hex);
        chk("cnt_bcd",  cnt_b,  dec2bcd(m_bcd));
        chk("tick_hex", tick_h, m_tick);
        chk("tick_bcd", tick_b, m_tick);
        chk("rc_hex",   rc_h,   u ? (m_hex == 8'hFF) : (m_hex == 8'h00));
        chk("rc_bcd",   rc_b,   u ? (m_bcd == 99) : (m_bcd == 0));
        chk("an_hex",   an_h,   m_an);
        chk("an_bcd",   an_b,   m_an);
        chk("seg_hex",  seg_h,  m_seg_h);
        chk("seg_bcd",  seg_b,  m_seg_b);
    endtask

    task automatic cycle(input logic ld, input logic [7:0] lv, input logic e, input logic u);
        load = ld; load_val = lv; en = e; up = u;
        @(posedge clk);
        model_step(ld, lv, e, u);
        #1;
        check_all(u);
    endtask

    typedef struct {
        logic       ld;
        logic [7:0] lv;
        logic       e;
        logic       u;
        int         n;
        logic [7:0] eh;
        logic [7:0] eb;
        logic       rh;
        logic       rb;
    } vec_t;

    vec_t tbl [10];
    int   lit0, pairs_ok;

    initial begin
        tbl[0] = '{1'b1, 8'hFE, 1'b1, 1'b1, 4, 8'hFF, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 4, 8'h00, 8'h01, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'h10, 1'b1, 1'b0, 4, 8'h0F, 8'h09, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 4, 8'h0E, 8'h08, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'h00, 1'b1, 1'b0, 0, 8'h00, 8'h00, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 4, 8'hFF, 8'h99, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 8'hA5, 1'b1, 1'b1, 0, 8'hA5, 8'h95, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 8'h3A, 1'b0, 1'b1, 6, 8'h3A, 8'h39, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 8'h99, 1'b1, 1'b1, 0, 8'h99, 8'h99, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 8, 8'h9B, 8'h01, 1'b0, 1'b0};

        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_cnt_hex", cnt_h, 8'h00);
        chk("rst_an_hex",  an_h,  2'b11);
        chk("rst_seg_hex", seg_h, 7'h7F);
        chk("rst_tick",    tick_h, 1'b0);
        rst_n = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("rel_an",  an_h,  2'b10);
        chk("rel_seg", seg_h, 7'b1000000);

        for (int r = 0; r < 10; r++) begin
            if (tbl[r].ld) cycle(1'b1, tbl[r].lv, tbl[r].e, tbl[r].u);
            for (int k = 0; k < tbl[r].n; k++) cycle(1'b0, 8'h00, tbl[r].e, tbl[r].u);
            chk($sformatf("vec%0d_cnt_hex", r), cnt_h, tbl[r].eh);
            chk($sformatf("vec%0d_cnt_bcd", r), cnt_b, tbl[r].eb);
            chk($sformatf("vec%0d_rc_hex", r),  rc_h,  tbl[r].rh);
            chk($sformatf("vec%0d_rc_bcd", r),  rc_b,  tbl[r].rb);
        end

        // load coinciding with a tick: load wins, next step a full period later
        cycle(1'b1, 8'h00, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b1, 8'h42, 1'b1, 1'b1);
        chk("coll_cnt_hex", cnt_h, 8'h42);
        chk("coll_cnt_bcd", cnt_b, 8'h42);
        chk("coll_tick",    tick_h, 1'b0);
        repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b1);
        chk("coll_hold", cnt_h, 8'h42);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        chk("coll_step",      cnt_h, 8'h43);
        chk("coll_step_tick", tick_h, 1'b1);

        // enable gating after two prescaler counts
        cycle(1'b1, 8'h00, 1'b1, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            chk("gate_cnt",  cnt_h,  8'h00);
            chk("gate_tick", tick_h, 1'b0);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        chk("gate_resume1", cnt_h, 8'h00);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        chk("gate_resume2", cnt_h, 8'h01);
        chk("gate_resume2_tick", tick_h, 1'b1);

        // scan of 8'h3A: digit 0 shows "A", digit 1 shows "3"
        cycle(1'b1, 8'h3A, 1'b0, 1'b1);
        lit0 = 0; pairs_ok = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            if (an_h == 2'b10) lit0++;
            if ((an_h == 2'b10 && seg_h == 7'b0001000) || (an_h == 2'b01 && seg_h == 7'b0110000))
                pairs_ok++;
        end
        chk("scan_digit0_share", lit0, 4);
        chk("scan_pairs", pairs_ok, 8);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic       ld, e, u;
            logic [7:0] lv;
            ld = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 3))
                0:       lv = 8'h00;
                1:       lv = 8'hFF;
                2:       lv = 8'h99;
                default: lv = 8'($urandom);
            endcase
            e = ($urandom_range(0, 4) != 0);
            u = ($urandom_range(0, 7) < 5);
            cycle(ld, lv, e, u);
        end

        // asynchronous reset in the middle of counting
        cycle(1'b1, 8'h57, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_cnt_hex", cnt_h, 8'h00);
        chk("arst_cnt_bcd", cnt_b, 8'h00);
        chk("arst_an",      an_h,  2'b11);
        chk("arst_seg",     seg_h, 7'h7F);
        chk("arst_tick",    tick_h, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("arel_an",  an_h,  2'b10);
        chk("arel_seg", seg_h, 7'b1000000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
